// File: rtl/name_suite_ren_issue_pkg.sv
// Shared constants and state encoding for the read-enable issue stage.
package name_suite_ren_issue_pkg;

  localparam int unsigned DEPTH_DEF   = 4;
  localparam int unsigned ADDR_W_DEF  = 8;
  localparam int unsigned MAX_OUT_DEF = 4;
  localparam int unsigned CNT_W       = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2
  } state_t;

endpackage

// File: rtl/name_suite_ren_issue_if.sv
// Request/issue/ack bundle between a requester and the read-enable issue stage.
interface name_suite_ren_issue_if
  import name_suite_ren_issue_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
);

  logic              io_req_valid;
  logic              io_req_ready;
  logic [ADDR_W-1:0] io_req_addr;
  logic              io_flush;
  logic              io_ack;
  logic              io_out_ren;
  logic [ADDR_W-1:0] io_out_addr;
  logic [CNT_W-1:0]  io_outstanding;
  logic              io_busy;
  logic              io_err;

  modport master (
    output io_req_valid, io_req_addr, io_flush, io_ack,
    input  io_req_ready, io_out_ren, io_out_addr, io_outstanding, io_busy, io_err
  );

  modport slave (
    input  io_req_valid, io_req_addr, io_flush, io_ack,
    output io_req_ready, io_out_ren, io_out_addr, io_outstanding, io_busy, io_err
  );

endinterface

// File: rtl/name_suite_ren_fifo.sv
// Request address FIFO with flush; extra pointer bit separates full from empty.
module name_suite_ren_fifo #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_data,
  input  logic              pop,
  input  logic              flush,
  output logic [ADDR_W-1:0] head,
  output logic              full,
  output logic              empty,
  output logic              empty_nxt_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = (PTR_W+1)'(1);

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [PTR_W:0]    wr_ptr, rd_ptr;
  logic [PTR_W:0]    wr_nxt, rd_nxt;
  logic              do_push;

  assign do_push = push && !full && !flush;

  // Flush wins over push and pop in the same cycle.
  always_comb begin
    wr_nxt = wr_ptr;
    rd_nxt = rd_ptr;
    if (flush) begin
      wr_nxt = '0;
      rd_nxt = '0;
    end else begin
      if (do_push)         wr_nxt = wr_ptr + PTR_ONE;
      if (pop && !empty)   rd_nxt = rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PTR_W-1:0]] <= push_data;
  end

  assign head        = mem[rd_ptr[PTR_W-1:0]];
  assign empty       = (wr_ptr == rd_ptr);
  assign full        = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                       (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign empty_nxt_c = (wr_nxt == rd_nxt);

endmodule

// File: rtl/name_suite_ren_issue.sv
// Issue stage: queues read requests, emits one ren pulse per request, and
// throttles in-flight reads with an ack-driven credit counter.
module name_suite_ren_issue
  import name_suite_ren_issue_pkg::*;
#(
  parameter int unsigned DEPTH   = DEPTH_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned MAX_OUT = MAX_OUT_DEF
) (
  input logic                    clk,
  input logic                    reset,
  name_suite_ren_issue_if.slave  bus
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  count, count_nxt;
  logic              err, err_nxt;
  logic              issue_c;
  logic              push_c;
  logic [ADDR_W-1:0] head;
  logic              full, empty, empty_nxt_c;

  name_suite_ren_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (push_c),
    .push_data   (bus.io_req_addr),
    .pop         (issue_c),
    .flush       (bus.io_flush),
    .head        (head),
    .full        (full),
    .empty       (empty),
    .empty_nxt_c (empty_nxt_c)
  );

  // Issue depends only on registered state, so the pulse never follows an input combinationally.
  assign issue_c = (state == ST_RUN) && !empty && (count < MAX_CNT);
  assign push_c  = bus.io_req_valid && !full && !bus.io_flush;

  always_comb begin
    count_nxt = count;
    err_nxt   = err;
    if (bus.io_ack && (count == '0)) err_nxt = 1'b1;
    unique case ({issue_c, bus.io_ack})
      2'b10:   count_nxt = count + CNT_ONE;
      2'b01:   count_nxt = (count == '0) ? '0 : count - CNT_ONE;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      err   <= 1'b0;
    end else begin
      count <= count_nxt;
      err   <= err_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Transitions look at post-edge FIFO occupancy and credit count.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (!empty_nxt_c) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (empty_nxt_c)                 state_nxt = ST_IDLE;
        else if (count_nxt == MAX_CNT)   state_nxt = ST_STALL;
      end
      ST_STALL: begin
        if (empty_nxt_c)                 state_nxt = ST_IDLE;
        else if (count_nxt < MAX_CNT)    state_nxt = ST_RUN;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign bus.io_req_ready   = !full;
  assign bus.io_out_ren     = issue_c;
  assign bus.io_out_addr    = issue_c ? head : '0;
  assign bus.io_outstanding = count;
  assign bus.io_busy        = !empty || (count != '0);
  assign bus.io_err         = err;

endmodule

// File: tb/tb_name_suite_ren_issue.sv
// Randomized scoreboard bench for the read-enable issue stage.
module tb_name_suite_ren_issue;
  import name_suite_ren_issue_pkg::*;

  localparam int unsigned AW = 8;
  localparam int unsigned DP = 4;
  localparam int unsigned MO = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  name_suite_ren_issue_if #(.ADDR_W(AW)) bus ();

  name_suite_ren_issue #(
    .DEPTH   (DP),
    .ADDR_W  (AW),
    .MAX_OUT (MO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int          cyc;
    logic [AW-1:0] addr;
  } exp_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  exp_t        sb[$];
  logic [AW-1:0] mq[$];
  int          m_cnt  = 0;
  bit          m_err  = 1'b0;
  bit          primed = 1'b0;
  int          mcyc   = 0;
  int          ncyc   = 0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", name, mcyc, act, req);
    end
  endtask

  // Reference model: a queue of pending addresses plus an in-flight counter.
  always @(negedge clk) begin : model
    bit iss, rdy;
    iss = (mq.size() > 0) && (m_cnt < int'(MO));
    rdy = (mq.size() < int'(DP));
    if (primed) begin
      check("req_ready",   int'(bus.io_req_ready),   int'(rdy));
      check("outstanding", int'(bus.io_outstanding), m_cnt);
      check("busy",        int'(bus.io_busy),        int'((mq.size() > 0) || (m_cnt != 0)));
      check("err",         int'(bus.io_err),         int'(m_err));
      if (iss) sb.push_back('{mcyc, mq[0]});
      else     check("idle_addr", int'(bus.io_out_addr), 0);
    end
    if (reset) begin
      mq.delete();
      m_cnt  = 0;
      m_err  = 1'b0;
      primed = 1'b1;
    end else begin
      if (bus.io_ack && m_cnt == 0) m_err = 1'b1;
      if (iss && !bus.io_ack)                    m_cnt++;
      else if (!iss && bus.io_ack && m_cnt > 0)  m_cnt--;
      if (iss) void'(mq.pop_front());
      if (bus.io_flush)                    mq.delete();
      else if (bus.io_req_valid && rdy)    mq.push_back(bus.io_req_addr);
    end
    mcyc++;
  end

  // Monitor: every observed pulse must match the next predicted issue.
  always @(negedge clk) begin : monitor
    exp_t e;
    #1;
    if (primed) begin
      if (bus.io_out_ren === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_ren", 1, 0);
        end else begin
          e = sb.pop_front();
          check("ren_cycle", ncyc, e.cyc);
          check("ren_addr", int'(bus.io_out_addr), int'(e.addr));
        end
      end else if (sb.size() > 0 && sb[0].cyc <= ncyc) begin
        e = sb.pop_front();
        check("missing_ren", 0, 1);
      end
    end
    ncyc++;
  end

  task automatic step(input bit v, input int a, input bit k, input bit f, input bit r = 1'b0);
    bus.io_req_valid = v;
    bus.io_req_addr  = AW'(a);
    bus.io_ack       = k;
    bus.io_flush     = f;
    reset            = r;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic push_hold(input int a, input bit ack_when_blocked);
    bit acc;
    for (int i = 0; i < 50; i++) begin
      acc = bus.io_req_ready;
      step(1'b1, a, ack_when_blocked && !acc && (m_cnt > 0), 1'b0);
      if (acc) return;
    end
    check("push_timeout", int'(bus.io_req_ready), 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && (m_cnt > 0 || mq.size() > 0); i++)
      step(1'b0, 0, (m_cnt > 0) && ($urandom_range(0, 1) == 1), 1'b0);
    idle(1);
    check("drain_busy", int'(bus.io_busy), 0);
  endtask

  initial begin
    reset            = 1'b1;
    bus.io_req_valid = 1'b0;
    bus.io_req_addr  = '0;
    bus.io_ack       = 1'b0;
    bus.io_flush     = 1'b0;
    step(1'b0, 0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 0, 1'b0, 1'b0, 1'b1);
    idle(1);

    // Back-to-back pushes, each acked two cycles after its pulse.
    step(1'b1, 'h11, 1'b0, 1'b0);
    step(1'b1, 'h22, 1'b0, 1'b0);
    step(1'b1, 'h33, 1'b0, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0);
    idle(2);

    // Credit limit, then a full FIFO with a held request.
    for (int i = 0; i < 6; i++) step(1'b1, 'h40 + i, 1'b0, 1'b0);
    idle(3);
    step(1'b0, 0, 1'b1, 1'b0);
    idle(2);
    push_hold('h50, 1'b0);
    push_hold('h51, 1'b0);
    push_hold('h52, 1'b0);
    push_hold('h53, 1'b1);
    drain();

    // Ack with nothing outstanding sets the sticky error.
    step(1'b0, 0, 1'b1, 1'b0);
    idle(3);
    step(1'b0, 0, 1'b0, 1'b0, 1'b1);
    idle(1);

    // Flush with queued work and reads in flight; same-cycle push is dropped.
    for (int i = 0; i < 7; i++) step(1'b1, 'h60 + i, 1'b0, 1'b0);
    idle(2);
    step(1'b1, 'h77, 1'b0, 1'b1);
    idle(2);
    drain();

    // Reset mid-stream.
    for (int i = 0; i < 5; i++) step(1'b1, 'h80 + i, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0, 1'b1);
    idle(2);

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      bit v, k, f, r;
      v = ($urandom_range(0, 99) < 60);
      k = ((m_cnt > 0) && ($urandom_range(0, 2) == 0)) || ($urandom_range(0, 99) == 0);
      f = ($urandom_range(0, 99) < 3);
      r = ($urandom_range(0, 199) == 0);
      step(v, int'($urandom_range(0, 255)), k, f, r);
    end
    drain();
    idle(2);
    check("scoreboard_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
